// File: rtl/axis_timer_reload_pkg.sv
// Shared constants for the beat-clocked reload timer: FSM state encodings and mode values.
package axis_timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/axis_timer_reload_if.sv
// Tick-source stream handshake; the timer side only ever accepts.
interface axis_timer_reload_if;

  logic tvalid;
  logic tready;

  modport master (output tvalid, input tready);
  modport slave  (input tvalid, output tready);

endinterface

// File: rtl/axis_timer_presc.sv
// Beat prescaler: turns every (presc_i + 1)-th enabled beat into a single tick.
module axis_timer_presc #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   beat_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  output logic                   tick_o
);

  logic [PRESC_WIDTH-1:0] cnt_q;
  logic [PRESC_WIDTH-1:0] cnt_d;

  // Beat counting; clear outranks beats, disabled beats hold the count.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = {PRESC_WIDTH{1'b0}};
    end else if (beat_i && en_i) begin
      if (cnt_q == presc_i) begin
        tick_o = 1'b1;
        cnt_d  = {PRESC_WIDTH{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= {PRESC_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_timer_reload.sv
// Down-counting timer ticked by accepted stream beats, with one-shot or periodic reload,
// pause via run_flag and a one-cycle terminal-count pulse.
module axis_timer_reload
  import axis_timer_pkg::*;
#(
  parameter int CNTR_WIDTH  = 64,
  parameter int PRESC_WIDTH = 16,
  parameter int RLD_WIDTH   = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   run_flag,
  input  logic                   cfg_flag,
  input  logic                   cfg_mode,
  input  logic [CNTR_WIDTH-1:0]  cfg_data,
  input  logic [PRESC_WIDTH-1:0] cfg_presc,
  output logic                   trg_flag,
  output logic                   trg_pulse,
  output logic [CNTR_WIDTH-1:0]  sts_data,
  output logic [1:0]             sts_state,
  output logic [RLD_WIDTH-1:0]   sts_reloads,
  axis_timer_reload_if.slave     s_axis
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RLD_WIDTH-1:0]  RLD_ONE  = {{(RLD_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state_q,   state_d;
  logic [CNTR_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [CNTR_WIDTH-1:0]  period_q,  period_d;
  logic [PRESC_WIDTH-1:0] presc_q,   presc_d;
  logic                   mode_q,    mode_d;
  logic [RLD_WIDTH-1:0]   rld_q,     rld_d;
  logic                   pulse_q,   pulse_d;
  logic                   flag_q,    flag_d;
  logic                   tick_s;
  logic                   beat_en_s;

  assign s_axis.tready = 1'b1;
  assign beat_en_s     = (state_q == ST_RUN) && run_flag;

  axis_timer_presc #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .aclk    (aclk),
    .areset  (areset),
    .beat_i  (s_axis.tvalid),
    .en_i    (beat_en_s),
    .clr_i   (cfg_flag),
    .presc_i (presc_q),
    .tick_o  (tick_s)
  );

  // Next-state logic: configuration first, then run/pause transitions, then ticks.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    rld_d    = rld_q;
    pulse_d  = 1'b0;
    if (cfg_flag) begin
      cnt_d    = cfg_data;
      period_d = cfg_data;
      presc_d  = cfg_presc;
      mode_d   = cfg_mode;
      rld_d    = {RLD_WIDTH{1'b0}};
      if (cfg_data == CNT_ZERO) begin
        state_d = ST_IDLE;
      end else if (run_flag) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_ARMED;
      end
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (run_flag) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_RUN: begin
          if (!run_flag) begin
            state_d = ST_ARMED;
          end else if (tick_s && (cnt_q > CNT_ONE)) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (tick_s && (cnt_q == CNT_ONE)) begin
            // Terminal count: reload and stay, or park at zero in DONE.
            pulse_d = 1'b1;
            rld_d   = rld_q + RLD_ONE;
            if (mode_q == MODE_PERIODIC) begin
              cnt_d = period_q;
            end else begin
              cnt_d   = CNT_ZERO;
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    flag_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      period_q <= CNT_ZERO;
      presc_q  <= {PRESC_WIDTH{1'b0}};
      mode_q   <= MODE_ONESHOT;
      rld_q    <= {RLD_WIDTH{1'b0}};
      pulse_q  <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      rld_q    <= rld_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
    end
  end

  assign trg_flag    = flag_q;
  assign trg_pulse   = pulse_q;
  assign sts_data    = cnt_q;
  assign sts_state   = state_q;
  assign sts_reloads = rld_q;

endmodule

// File: tb/tb_axis_timer_reload.sv
// Self-checking bench: a behavioural timer model pushes expected outputs per driven cycle,
// which are popped and compared one cycle later; directed scenarios add fixed-value checks.
module tb_axis_timer_reload;

  typedef struct {
    logic [1:0]  state;
    logic [63:0] data;
    logic        pulse;
    logic        flag;
    logic [31:0] rld;
  } exp_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        run_flag;
  logic        cfg_flag;
  logic        cfg_mode;
  logic [63:0] cfg_data;
  logic [15:0] cfg_presc;
  logic        trg_flag;
  logic        trg_pulse;
  logic [63:0] sts_data;
  logic [1:0]  sts_state;
  logic [31:0] sts_reloads;

  axis_timer_reload_if s_axis_if ();

  axis_timer_reload dut (
    .aclk        (aclk),
    .areset      (areset),
    .run_flag    (run_flag),
    .cfg_flag    (cfg_flag),
    .cfg_mode    (cfg_mode),
    .cfg_data    (cfg_data),
    .cfg_presc   (cfg_presc),
    .trg_flag    (trg_flag),
    .trg_pulse   (trg_pulse),
    .sts_data    (sts_data),
    .sts_state   (sts_state),
    .sts_reloads (sts_reloads),
    .s_axis      (s_axis_if.slave)
  );

  always #5 aclk = ~aclk;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   pulse_cnt = 0;
  exp_t exp_q[$];

  logic [1:0]  m_state = 2'd0;
  logic [63:0] m_cnt = 64'd0;
  logic [63:0] m_period = 64'd0;
  logic [15:0] m_presc = 16'd0;
  logic        m_mode = 1'b0;
  logic [15:0] m_pcnt = 16'd0;
  logic [31:0] m_rld = 32'd0;
  logic        m_pulse = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge given the inputs driven this cycle.
  task automatic model_edge(input logic rst, input logic cfg, input logic mode,
                            input logic [63:0] data, input logic [15:0] presc,
                            input logic run, input logic tv);
    logic tick;
    tick    = 1'b0;
    m_pulse = 1'b0;
    if (rst) begin
      m_state = 2'd0; m_cnt = 64'd0; m_period = 64'd0; m_presc = 16'd0;
      m_mode = 1'b0; m_pcnt = 16'd0; m_rld = 32'd0;
    end else if (cfg) begin
      m_cnt = data; m_period = data; m_presc = presc; m_mode = mode;
      m_pcnt = 16'd0; m_rld = 32'd0;
      m_state = (data == 64'd0) ? 2'd0 : (run ? 2'd2 : 2'd1);
    end else if (m_state == 2'd1) begin
      if (run) m_state = 2'd2;
    end else if (m_state == 2'd2) begin
      if (!run) begin
        m_state = 2'd1;
      end else if (tv) begin
        if (m_pcnt == m_presc) begin
          m_pcnt = 16'd0;
          tick = 1'b1;
        end else begin
          m_pcnt = m_pcnt + 16'd1;
        end
      end
      if (tick) begin
        if (m_cnt > 64'd1) begin
          m_cnt = m_cnt - 64'd1;
        end else if (m_cnt == 64'd1) begin
          m_pulse = 1'b1;
          m_rld = m_rld + 32'd1;
          if (m_mode) m_cnt = m_period;
          else begin m_cnt = 64'd0; m_state = 2'd3; end
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic cfg, input logic mode,
                      input logic [63:0] data, input logic [15:0] presc,
                      input logic run, input logic tv);
    exp_t e;
    areset = rst; cfg_flag = cfg; cfg_mode = mode; cfg_data = data;
    cfg_presc = presc; run_flag = run; s_axis_if.tvalid = tv;
    model_edge(rst, cfg, mode, data, presc, run, tv);
    e.state = m_state; e.data = m_cnt; e.pulse = m_pulse;
    e.flag = (m_state == 2'd2); e.rld = m_rld;
    exp_q.push_back(e);
    @(posedge aclk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("state", {62'd0, sts_state}, {62'd0, e.state});
      chk("data", sts_data, e.data);
      chk("pulse", {63'd0, trg_pulse}, {63'd0, e.pulse});
      chk("flag", {63'd0, trg_flag}, {63'd0, e.flag});
      chk("reloads", {32'd0, sts_reloads}, {32'd0, e.rld});
      chk("tready", {63'd0, s_axis_if.tready}, 64'd1);
    end
    if (trg_pulse) pulse_cnt++;
  endtask

  // Plain run cycle: no reset, no configuration.
  task automatic tick_cyc(input logic run, input logic tv);
    step(1'b0, 1'b0, 1'b0, 64'd0, 16'd0, run, tv);
  endtask

  initial begin
    areset = 1'b1; run_flag = 1'b0; cfg_flag = 1'b0; cfg_mode = 1'b0;
    cfg_data = 64'd0; cfg_presc = 16'd0; s_axis_if.tvalid = 1'b0;
    #1;
    step(1'b1, 1'b0, 1'b0, 64'd0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'd0, 16'd0, 1'b0, 1'b0);
    chk("rst_state", {62'd0, sts_state}, 64'd0);
    chk("rst_data", sts_data, 64'd0);

    // One-shot, period 3, every beat a tick.
    step(1'b0, 1'b1, 1'b0, 64'd3, 16'd0, 1'b1, 1'b1);
    chk("os_load", sts_data, 64'd3);
    tick_cyc(1'b1, 1'b1); chk("os_2", sts_data, 64'd2);
    tick_cyc(1'b1, 1'b1); chk("os_1", sts_data, 64'd1);
    tick_cyc(1'b1, 1'b1);
    chk("os_0", sts_data, 64'd0);
    chk("os_pulse", {63'd0, trg_pulse}, 64'd1);
    chk("os_done", {62'd0, sts_state}, 64'd3);
    chk("os_rld", {32'd0, sts_reloads}, 64'd1);
    tick_cyc(1'b1, 1'b1);
    chk("os_pulse_end", {63'd0, trg_pulse}, 64'd0);
    chk("os_hold", sts_data, 64'd0);

    // Periodic, period 2, prescale 3 beats per tick.
    step(1'b0, 1'b1, 1'b1, 64'd2, 16'd2, 1'b1, 1'b1);
    pulse_cnt = 0;
    for (int i = 0; i < 12; i++) tick_cyc(1'b1, 1'b1);
    chk("per_pulses", pulse_cnt, 64'd2);
    chk("per_rld", {32'd0, sts_reloads}, 64'd2);

    // Pause at 5 with a partially filled prescaler, then resume.
    step(1'b0, 1'b1, 1'b1, 64'd8, 16'd1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) tick_cyc(1'b1, 1'b1);
    chk("pz_at5", sts_data, 64'd5);
    for (int i = 0; i < 4; i++) tick_cyc(1'b0, 1'b1);
    chk("pz_armed", {62'd0, sts_state}, 64'd1);
    chk("pz_hold", sts_data, 64'd5);
    tick_cyc(1'b1, 1'b1);
    chk("pz_resume", sts_data, 64'd5);
    tick_cyc(1'b1, 1'b1);
    chk("pz_presc_kept", sts_data, 64'd4);

    // Configuration on a terminal-tick cycle wins.
    step(1'b0, 1'b1, 1'b1, 64'd2, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick_cyc(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 64'd7, 16'd0, 1'b1, 1'b1);
    chk("cfgw_pulse", {63'd0, trg_pulse}, 64'd0);
    chk("cfgw_data", sts_data, 64'd7);
    chk("cfgw_rld", {32'd0, sts_reloads}, 64'd0);

    // Disarm with period 0.
    step(1'b0, 1'b1, 1'b1, 64'd0, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick_cyc(1'b1, 1'b1);
    chk("idle_state", {62'd0, sts_state}, 64'd0);
    chk("idle_flag", {63'd0, trg_flag}, 64'd0);

    // Periodic period 1: a pulse on every beat.
    step(1'b0, 1'b1, 1'b1, 64'd1, 16'd0, 1'b1, 1'b0);
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) tick_cyc(1'b1, (i % 3) != 2);
    chk("p1_pulses", pulse_cnt, 64'd6);

    // Reset mid-run at 10 beats a simultaneous configuration.
    step(1'b0, 1'b1, 1'b1, 64'd12, 16'd0, 1'b1, 1'b1);
    tick_cyc(1'b1, 1'b1); tick_cyc(1'b1, 1'b1);
    chk("ar_at10", sts_data, 64'd10);
    step(1'b1, 1'b1, 1'b1, 64'd5, 16'd0, 1'b1, 1'b1);
    chk("ar_data", sts_data, 64'd0);
    chk("ar_state", {62'd0, sts_state}, 64'd0);
    chk("ar_flag", {63'd0, trg_flag}, 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)),
           64'($urandom_range(0, 6)), 16'($urandom_range(0, 2)),
           ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 70));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
